// File: rtl/control_unit_if.sv
// Control/bus bundle between the sequencer, its synchronous instruction ROM and the datapath.
// master = control_unit; slave = ROM/datapath side.
interface control_unit_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            alu_en;
  logic [3:0]      alu_opcode;
  logic [7:0]      user_write_data;
  logic [3:0]      write_addr;
  logic [3:0]      ra_addr;
  logic [3:0]      rb_addr;
  logic            write_en;
  logic            alu_zero;
  logic            alu_carry;
  logic            busy;
  logic            halted;

  modport master (
    input  start, imem_rdata, alu_zero, alu_carry,
    output imem_addr, alu_en, alu_opcode, user_write_data, write_addr,
           ra_addr, rb_addr, write_en, busy, halted
  );

  modport slave (
    output start, imem_rdata, alu_zero, alu_carry,
    input  imem_addr, alu_en, alu_opcode, user_write_data, write_addr,
           ra_addr, rb_addr, write_en, busy, halted
  );
endinterface

// File: rtl/control_unit.sv
// Three-cycle FETCH/DECODE/EXEC sequencer for a 16-bit ISA: fetches from a synchronous ROM,
// drives regfile/ALU controls for one EXEC cycle and resolves JMP/BZ/BC from registered flags.
module control_unit #(
  parameter int PC_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_ALU_MAX = 4'h9;
  localparam logic [3:0] OP_LDI     = 4'hA;
  localparam logic [3:0] OP_JMP     = 4'hB;
  localparam logic [3:0] OP_BZ      = 4'hC;
  localparam logic [3:0] OP_BC      = 4'hD;
  localparam logic [3:0] OP_HALT    = 4'hF;

  state_t          state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [15:0]     instr_reg;
  logic            z_reg;
  logic            c_reg;
  logic            alu_en_reg;
  logic            write_en_reg;
  logic [7:0]      user_write_data_reg;

  logic [3:0]      exec_op;
  logic [3:0]      fetch_op;
  logic            taken;
  logic [PC_W-1:0] pc_next;

  assign exec_op  = instr_reg[15:12];
  assign fetch_op = bus.imem_rdata[15:12];

  always_comb begin
    taken   = (exec_op == OP_JMP) ||
              ((exec_op == OP_BZ) && z_reg) ||
              ((exec_op == OP_BC) && c_reg);
    pc_next = taken ? PC_W'(instr_reg[7:0]) : pc_reg + PC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= S_IDLE;
      pc_reg              <= '0;
      instr_reg           <= '0;
      z_reg               <= 1'b0;
      c_reg               <= 1'b0;
      alu_en_reg          <= 1'b0;
      write_en_reg        <= 1'b0;
      user_write_data_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            pc_reg    <= '0;
            z_reg     <= 1'b0;
            c_reg     <= 1'b0;
            state_reg <= S_FETCH;
          end
        end
        S_FETCH: state_reg <= S_DECODE;
        S_DECODE: begin
          // Controls are decoded straight off the ROM word so they are registered for EXEC.
          instr_reg           <= bus.imem_rdata;
          alu_en_reg          <= (fetch_op <= OP_ALU_MAX);
          write_en_reg        <= (fetch_op <= OP_LDI);
          user_write_data_reg <= (fetch_op == OP_LDI) ? bus.imem_rdata[7:0] : 8'h00;
          state_reg           <= S_EXEC;
        end
        S_EXEC: begin
          alu_en_reg          <= 1'b0;
          write_en_reg        <= 1'b0;
          user_write_data_reg <= '0;
          if (exec_op <= OP_ALU_MAX) begin
            z_reg <= bus.alu_zero;
            c_reg <= bus.alu_carry;
          end
          if (exec_op == OP_HALT) begin
            state_reg <= S_HALT;
          end else begin
            pc_reg    <= pc_next;
            state_reg <= S_FETCH;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // The address register is the pc itself: it only moves at the end of EXEC or on start.
  assign bus.imem_addr       = pc_reg;
  assign bus.alu_en          = alu_en_reg;
  assign bus.alu_opcode      = instr_reg[15:12];
  assign bus.user_write_data = user_write_data_reg;
  assign bus.write_addr      = instr_reg[11:8];
  assign bus.ra_addr         = instr_reg[7:4];
  assign bus.rb_addr         = instr_reg[3:0];
  // A reset arriving in EXEC must kill the regfile write on that same edge.
  assign bus.write_en        = write_en_reg & ~rst;
  assign bus.busy            = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                               (state_reg == S_EXEC);
  assign bus.halted          = (state_reg == S_HALT);
endmodule
